// File: rtl/secuenciador_datos_rtc.sv
// Reads N_DATOS bytes from the RTC interface once per vertical blanking and
// publishes them to the display atomically; a stalled transfer aborts with a sticky error.
module secuenciador_datos_rtc #(
  parameter int N_DATOS = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_frame,
  input  logic                   habilitar,
  input  logic                   dato_valido,
  input  logic [7:0]             datoRTC,
  output logic                   inicioSecuencia,
  output logic                   ocupado,
  output logic [2:0]             dato_idx,
  output logic [8*N_DATOS-1:0]   datos_pantalla,
  output logic                   actualizado,
  output logic                   error_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURA = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;
  localparam logic [1:0] ABORTA  = 2'd3;

  localparam logic [2:0]       ULTIMO_IDX = 3'(N_DATOS - 1);
  localparam logic [CNT_W-1:0] CNT_LIMITE = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]       estado;
  logic [1:0]       estado_sig;
  logic [CNT_W-1:0] cnt_timeout;
  logic [7:0]       shadow [N_DATOS];

  logic arranque;
  logic captura_ok;
  logic fin_captura;
  logic vence_timeout;

  assign arranque      = (estado == IDLE) && tick_frame && habilitar;
  assign captura_ok    = (estado == CAPTURA) && dato_valido;
  assign fin_captura   = captura_ok && (dato_idx == ULTIMO_IDX);
  // A valid byte on the limit cycle takes priority over the timeout.
  assign vence_timeout = (estado == CAPTURA) && !dato_valido && (cnt_timeout >= CNT_LIMITE);

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (arranque) estado_sig = CAPTURA;
      CAPTURA: begin
        if (fin_captura)        estado_sig = COMMIT;
        else if (vence_timeout) estado_sig = ABORTA;
      end
      COMMIT:  estado_sig = IDLE;
      ABORTA:  estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track the FSM edge-for-edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado          <= IDLE;
      ocupado         <= 1'b0;
      inicioSecuencia <= 1'b0;
    end else begin
      estado          <= estado_sig;
      ocupado         <= (estado_sig != IDLE);
      inicioSecuencia <= (estado_sig == CAPTURA);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dato_idx    <= 3'd0;
      cnt_timeout <= '0;
    end else if (arranque) begin
      dato_idx    <= 3'd0;
      cnt_timeout <= '0;
    end else if (captura_ok) begin
      cnt_timeout <= '0;
      if (!fin_captura) dato_idx <= dato_idx + 3'd1;
    end else if ((estado == CAPTURA) && (cnt_timeout != CNT_MAX)) begin
      cnt_timeout <= cnt_timeout + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_DATOS; k++) shadow[k] <= 8'd0;
    end else if (captura_ok) begin
      shadow[dato_idx] <= datoRTC;
    end
  end

  // The display only ever sees a complete frame, copied in one edge out of COMMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      datos_pantalla <= '0;
      actualizado    <= 1'b0;
      error_timeout  <= 1'b0;
    end else begin
      actualizado <= (estado == COMMIT);
      if (estado == COMMIT) begin
        for (int k = 0; k < N_DATOS; k++) datos_pantalla[8*k +: 8] <= shadow[k];
        error_timeout <= 1'b0;
      end else if (vence_timeout) begin
        error_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_datos_rtc.sv
// Self-checking bench: a directed vector table, hand-written corner sequences and
// randomized traffic, all compared against a transaction-level model of the sequencer.
module tb_secuenciador_datos_rtc;

  localparam int N  = 8;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick_frame = 1'b0;
  logic         habilitar = 1'b0;
  logic         dato_valido = 1'b0;
  logic [7:0]   datoRTC = 8'd0;
  logic         inicioSecuencia;
  logic         ocupado;
  logic [2:0]   dato_idx;
  logic [8*N-1:0] datos_pantalla;
  logic         actualizado;
  logic         error_timeout;

  int total = 0;
  int bad   = 0;

  // Reference model: a sequence is a queue of collected bytes plus a silence count.
  logic         m_activo;
  logic         m_commit_pend;
  logic         m_abort_pend;
  logic [7:0]   m_cola[$];
  int           m_silencio;
  int           m_idx;
  logic [8*N-1:0] m_pantalla;
  logic         m_act;
  logic         m_err;

  typedef struct {
    logic       tick;
    logic       hab;
    logic       val;
    logic [7:0] dat;
    logic       e_ini;
    logic       e_ocu;
    logic [2:0] e_idx;
    logic       e_act;
  } vec_t;

  vec_t tabla[11];

  secuenciador_datos_rtc #(.N_DATOS(N), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .tick_frame(tick_frame),
    .habilitar(habilitar),
    .dato_valido(dato_valido),
    .datoRTC(datoRTC),
    .inicioSecuencia(inicioSecuencia),
    .ocupado(ocupado),
    .dato_idx(dato_idx),
    .datos_pantalla(datos_pantalla),
    .actualizado(actualizado),
    .error_timeout(error_timeout)
  );

  always #5 clk = ~clk;

  task automatic modelo_reset();
    m_activo      = 1'b0;
    m_commit_pend = 1'b0;
    m_abort_pend  = 1'b0;
    m_cola.delete();
    m_silencio    = 0;
    m_idx         = 0;
    m_pantalla    = '0;
    m_act         = 1'b0;
    m_err         = 1'b0;
  endtask

  task automatic modelo_paso(input logic t, input logic h, input logic v, input logic [7:0] d);
    m_act = 1'b0;
    if (m_commit_pend) begin
      for (int k = 0; k < N; k++) m_pantalla[8*k +: 8] = m_cola[k];
      m_act = 1'b1;
      m_err = 1'b0;
      m_commit_pend = 1'b0;
    end else if (m_abort_pend) begin
      m_abort_pend = 1'b0;
    end else if (m_activo) begin
      if (v) begin
        m_cola.push_back(d);
        m_silencio = 0;
        m_idx = (m_cola.size() < N) ? m_cola.size() : N - 1;
        if (m_cola.size() == N) begin
          m_activo = 1'b0;
          m_commit_pend = 1'b1;
        end
      end else begin
        m_silencio++;
        if (m_silencio >= TO) begin
          m_activo = 1'b0;
          m_abort_pend = 1'b1;
          m_err = 1'b1;
        end
      end
    end else if (t && h) begin
      m_activo = 1'b1;
      m_cola.delete();
      m_silencio = 0;
      m_idx = 0;
    end
  endtask

  task automatic applyStimulus(input logic t, input logic h, input logic v, input logic [7:0] d);
    tick_frame  = t;
    habilitar   = h;
    dato_valido = v;
    datoRTC     = d;
    @(posedge clk);
    modelo_paso(t, h, v, d);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name);
    logic e_ocu;
    e_ocu = m_activo | m_commit_pend | m_abort_pend;
    total++;
    if (inicioSecuencia !== m_activo || ocupado !== e_ocu || dato_idx !== 3'(m_idx) ||
        actualizado !== m_act || error_timeout !== m_err || datos_pantalla !== m_pantalla) begin
      bad++;
      $display("[TB] FAIL %s: got ini=%b ocu=%b idx=%0d act=%b err=%b pant=%h want ini=%b ocu=%b idx=%0d act=%b err=%b pant=%h",
               name, inicioSecuencia, ocupado, dato_idx, actualizado, error_timeout, datos_pantalla,
               m_activo, e_ocu, m_idx, m_act, m_err, m_pantalla);
    end
  endtask

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic ciclo(input string name, input logic t, input logic h, input logic v, input logic [7:0] d);
    applyStimulus(t, h, v, d);
    checkOutput(name);
  endtask

  task automatic reposo(input string name, input int n);
    for (int i = 0; i < n; i++) ciclo(name, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] bytes_norm[8];
    logic [7:0] bytes_alt[8];
    int n_ini;
    int p_val;

    bytes_norm = '{8'h18, 8'h04, 8'h03, 8'h17, 8'h0C, 8'h15, 8'h05, 8'h06};
    bytes_alt  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};

    tabla[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0};
    tabla[1]  = '{1'b0, 1'b1, 1'b1, 8'h18, 1'b1, 1'b1, 3'd1, 1'b0};
    tabla[2]  = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 3'd2, 1'b0};
    tabla[3]  = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 3'd3, 1'b0};
    tabla[4]  = '{1'b0, 1'b1, 1'b1, 8'h17, 1'b1, 1'b1, 3'd4, 1'b0};
    tabla[5]  = '{1'b0, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b1, 3'd5, 1'b0};
    tabla[6]  = '{1'b0, 1'b1, 1'b1, 8'h15, 1'b1, 1'b1, 3'd6, 1'b0};
    tabla[7]  = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 3'd7, 1'b0};
    tabla[8]  = '{1'b0, 1'b1, 1'b1, 8'h06, 1'b0, 1'b1, 3'd7, 1'b0};
    tabla[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b1};
    tabla[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b0};

    // Reset state
    modelo_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_state");

    // Normal sequence from the vector table
    n_ini = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tabla[i].tick, tabla[i].hab, tabla[i].val, tabla[i].dat);
      checkOutput("vec_model");
      if (inicioSecuencia) n_ini++;
      total++;
      if (inicioSecuencia !== tabla[i].e_ini || ocupado !== tabla[i].e_ocu ||
          dato_idx !== tabla[i].e_idx || actualizado !== tabla[i].e_act) begin
        bad++;
        $display("[TB] FAIL vec_%0d: got ini=%b ocu=%b idx=%0d act=%b want ini=%b ocu=%b idx=%0d act=%b",
                 i, inicioSecuencia, ocupado, dato_idx, actualizado,
                 tabla[i].e_ini, tabla[i].e_ocu, tabla[i].e_idx, tabla[i].e_act);
      end
    end
    checkValue("ini_cycles", 64'(n_ini), 64'd8);
    checkValue("pantalla_norm", datos_pantalla, 64'h0605150C17030418);

    // Gapped data with 10 idle cycles between bytes 3 and 4
    ciclo("gap_tick", 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) reposo("gap_idle", 10);
      ciclo("gap_byte", 1'b0, 1'b1, 1'b1, bytes_norm[i]);
    end
    reposo("gap_tail", 3);
    checkValue("pantalla_gap", datos_pantalla, 64'h0605150C17030418);
    checkValue("err_gap", 64'(error_timeout), 64'd0);

    // Timeout: 3 bytes then a 64-cycle silence
    ciclo("to_tick", 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) ciclo("to_byte", 1'b0, 1'b1, 1'b1, bytes_alt[i]);
    reposo("to_silence", TO - 1);
    checkValue("to_still_running", 64'(inicioSecuencia), 64'd1);
    ciclo("to_expire", 1'b0, 1'b1, 1'b0, 8'h00);
    checkValue("to_err_set", 64'(error_timeout), 64'd1);
    checkValue("to_ini_drop", 64'(inicioSecuencia), 64'd0);
    reposo("to_after", 3);
    checkValue("to_pantalla_kept", datos_pantalla, 64'h0605150C17030418);
    checkValue("to_err_sticky", 64'(error_timeout), 64'd1);

    // Valid on the limit cycle wins; the commit then clears the error
    ciclo("lim_tick", 1'b1, 1'b1, 1'b0, 8'h00);
    reposo("lim_silence", TO - 1);
    for (int i = 0; i < 8; i++) ciclo("lim_byte", 1'b0, 1'b1, 1'b1, bytes_alt[i]);
    reposo("lim_tail", 2);
    checkValue("lim_pantalla", datos_pantalla, 64'h1807F6E5D4C3B2A1);
    checkValue("lim_err_clear", 64'(error_timeout), 64'd0);

    // Ignored ticks and habilitar dropped mid-sequence
    ciclo("ign_tick_dis", 1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("ign_no_start", 64'(ocupado), 64'd0);
    ciclo("ign_tick", 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        ciclo("ign_tick_cap", 1'b1, 1'b0, 1'b0, 8'h00);
        checkValue("ign_idx_kept", 64'(dato_idx), 64'd3);
      end
      ciclo("ign_byte", 1'b0, (i < 2) ? 1'b1 : 1'b0, 1'b1, bytes_norm[i]);
    end
    reposo("ign_tail", 2);
    checkValue("ign_pantalla", datos_pantalla, 64'h0605150C17030418);

    // Asynchronous reset after byte 5
    ciclo("rst_tick", 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) ciclo("rst_byte", 1'b0, 1'b1, 1'b1, bytes_alt[i]);
    tick_frame = 1'b0;
    dato_valido = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkValue("rst_ctrl", 64'({inicioSecuencia, ocupado, dato_idx, actualizado, error_timeout}), 64'd0);
    checkValue("rst_pantalla", datos_pantalla, 64'd0);
    #1 reset = 1'b0;
    modelo_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) ciclo("rst_no_start", 1'b0, 1'b1, 1'b1, 8'hAA);
    ciclo("rst_tick2", 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) ciclo("rst_seq", 1'b0, 1'b1, 1'b1, 8'(i + 1));
    reposo("rst_tail", 2);
    checkValue("rst_pantalla_new", datos_pantalla, 64'h0807060504030201);

    // Randomized traffic with varying data density
    p_val = 90;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: p_val = 95;
          1: p_val = 50;
          2: p_val = 10;
          default: p_val = 1;
        endcase
      end
      ciclo("rand", ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < p_val) ? 1'b1 : 1'b0,
            8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
